// File: rtl/cs_resolve_mod.sv
// cs_resolve_mod: resolves a carry-save pair (S, C) to binary with a chunked
// multi-cycle carry-propagate adder, then reduces the value into [0, Q).
// The adder and the trial subtraction of Q run side by side, LSB chunk first,
// so the final borrow selects V or V-Q without a second pass.
// Optional feature macro: CS_RESOLVE_RANGE_CHK_EN adds o_range_err, which
// flags inputs that break the V < 2Q contract.
module cs_resolve_mod #(
  parameter int WIDTH = 255,
  parameter int CHUNK = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH:0]   i_sum,
  input  logic [WIDTH:0]   i_carry,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result
`ifdef CS_RESOLVE_RANGE_CHK_EN
  ,
  output logic             o_range_err
`endif
);

  localparam int W1        = WIDTH + 1;
  localparam int NCH       = (W1 + CHUNK - 1) / CHUNK;
  localparam int PW        = NCH * CHUNK;
  localparam int CW        = $clog2(NCH + 1);
  localparam int LAST_BITS = W1 - (NCH - 1) * CHUNK;

  // Bits of the top chunk that lie inside the WIDTH+1 value; the rest are padding.
  function automatic logic [CHUNK-1:0] last_mask_f();
    logic [CHUNK-1:0] m;
    m = '0;
    for (int i = 0; i < CHUNK; i++) begin
      m[i] = (i < LAST_BITS);
    end
    return m;
  endfunction

  localparam logic [CHUNK-1:0] LAST_MASK = last_mask_f();

  // One chunk of the carry-propagate adder; bit CHUNK is the carry-out.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             ci);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  endfunction

  // One chunk of a borrow-propagate subtractor; bit CHUNK is the borrow-out.
  function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             bi);
    return {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bi};
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   s_sh_q, s_sh_d;
  logic [PW-1:0]   c_sh_q, c_sh_d;
  logic [PW-1:0]   q_sh_q, q_sh_d;
  logic [PW-1:0]   acc_v_q, acc_v_d;
  logic [PW-1:0]   acc_d_q, acc_d_d;
  logic            cy_q, cy_d;
  logic            bw_q, bw_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [CHUNK:0]   v_full;
  logic [CHUNK:0]   d_full;
  logic [CHUNK-1:0] v_k;
  logic             last_chunk;

`ifdef CS_RESOLVE_RANGE_CHK_EN
  logic             q2c_q, q2c_d;
  logic             bw2_q, bw2_d;
  logic [CHUNK-1:0] tq_k;
  logic [CHUNK:0]   e_full;
`endif

  // Chunk datapath: add the current S/C chunk, then subtract the Q chunk from it.
  always_comb begin
    last_chunk = (cnt_q == CW'(NCH - 1));
    v_full     = add_chunk(s_sh_q[CHUNK-1:0], c_sh_q[CHUNK-1:0], cy_q);
    // The carry out of bit WIDTH is dropped by masking the padding bits.
    v_k        = v_full[CHUNK-1:0] & (last_chunk ? LAST_MASK : {CHUNK{1'b1}});
    d_full     = sub_chunk(v_k, q_sh_q[CHUNK-1:0], bw_q);
`ifdef CS_RESOLVE_RANGE_CHK_EN
    // Chunk of 2Q: Q shifted left by one, MSB of the previous Q chunk enters at bit 0.
    tq_k       = {q_sh_q[CHUNK-2:0], q2c_q};
    e_full     = sub_chunk(v_k, tq_k, bw2_q);
`endif
  end

  // FSM next state and all datapath next-state values.
  always_comb begin
    state_d = state_q;
    s_sh_d  = s_sh_q;
    c_sh_d  = c_sh_q;
    q_sh_d  = q_sh_q;
    acc_v_d = acc_v_q;
    acc_d_d = acc_d_q;
    cy_d    = cy_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
`ifdef CS_RESOLVE_RANGE_CHK_EN
    q2c_d   = q2c_q;
    bw2_d   = bw2_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_in_valid) begin
          s_sh_d  = PW'(i_sum);
          c_sh_d  = PW'(i_carry);
          q_sh_d  = PW'(i_q);
          cy_d    = 1'b0;
          bw_d    = 1'b0;
          cnt_d   = '0;
`ifdef CS_RESOLVE_RANGE_CHK_EN
          q2c_d   = 1'b0;
          bw2_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        cy_d    = v_full[CHUNK];
        bw_d    = d_full[CHUNK];
        // Results enter from the top so chunk 0 lands at bit 0 after NCH steps.
        if (NCH > 1) begin
          acc_v_d = {v_k, acc_v_q[PW-1:CHUNK]};
          acc_d_d = {d_full[CHUNK-1:0], acc_d_q[PW-1:CHUNK]};
          s_sh_d  = s_sh_q >> CHUNK;
          c_sh_d  = c_sh_q >> CHUNK;
          q_sh_d  = q_sh_q >> CHUNK;
        end else begin
          acc_v_d = v_k;
          acc_d_d = d_full[CHUNK-1:0];
        end
`ifdef CS_RESOLVE_RANGE_CHK_EN
        q2c_d   = q_sh_q[CHUNK-1];
        bw2_d   = e_full[CHUNK];
`endif
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      s_sh_q  <= '0;
      c_sh_q  <= '0;
      q_sh_q  <= '0;
      acc_v_q <= '0;
      acc_d_q <= '0;
      cy_q    <= 1'b0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef CS_RESOLVE_RANGE_CHK_EN
      q2c_q   <= 1'b0;
      bw2_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_sh_q  <= s_sh_d;
      c_sh_q  <= c_sh_d;
      q_sh_q  <= q_sh_d;
      acc_v_q <= acc_v_d;
      acc_d_q <= acc_d_d;
      cy_q    <= cy_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
`ifdef CS_RESOLVE_RANGE_CHK_EN
      q2c_q   <= q2c_d;
      bw2_q   <= bw2_d;
`endif
    end
  end

  // Final borrow set means V < Q, so V itself is already reduced.
  assign o_in_ready  = (state_q == IDLE);
  assign o_out_valid = (state_q == DONE);
  assign o_result    = (state_q == DONE) ?
                       (bw_q ? acc_v_q[WIDTH-1:0] : acc_d_q[WIDTH-1:0]) : '0;

`ifdef CS_RESOLVE_RANGE_CHK_EN
  // No final borrow from V - 2Q means V >= 2Q.
  assign o_range_err = (state_q == DONE) & ~bw2_q;
`endif

  // Padding and result bits above WIDTH-1 never reach an output.
  logic unused_bits;
`ifdef CS_RESOLVE_RANGE_CHK_EN
  assign unused_bits = ^{acc_v_q[PW-1:WIDTH], acc_d_q[PW-1:WIDTH], e_full[CHUNK-1:0]};
`else
  assign unused_bits = ^{acc_v_q[PW-1:WIDTH], acc_d_q[PW-1:WIDTH]};
`endif

endmodule

// File: tb/tb_cs_resolve_mod.sv
// Bench for cs_resolve_mod at default parameters (WIDTH=255, CHUNK=32).
module tb_cs_resolve_mod;

  localparam int WIDTH = 255;
  localparam int NCH   = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH:0]   i_sum;
  logic [WIDTH:0]   i_carry;
  logic [WIDTH-1:0] i_q;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_result;
`ifdef CS_RESOLVE_RANGE_CHK_EN
  logic             o_range_err;
`endif

  cs_resolve_mod #(.WIDTH(WIDTH), .CHUNK(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_sum       (i_sum),
    .i_carry     (i_carry),
    .i_q         (i_q),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result)
`ifdef CS_RESOLVE_RANGE_CHK_EN
    ,
    .o_range_err (o_range_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  logic [254:0] QM;
  logic [255:0] Q256;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the whole value.
  function automatic logic [254:0] ref_res(input logic [255:0] s, input logic [255:0] c,
                                           input logic [254:0] q);
    logic [255:0] v, r;
    v = s + c;
    if (v < {1'b0, q}) r = v;
    else               r = v - {1'b0, q};
    return r[254:0];
  endfunction

  function automatic logic ref_rerr(input logic [255:0] s, input logic [255:0] c,
                                    input logic [254:0] q);
    logic [255:0] v;
    v = s + c;
    return (v >= {q, 1'b0});
  endfunction

  // Transaction-level model: accept when free, result due NCH edges later,
  // held until the consumer takes it.
  logic         mdl_ready, mdl_valid, mdl_rerr;
  int           mdl_wait;
  logic [254:0] mdl_res;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mdl_ready <= 1'b1;
      mdl_valid <= 1'b0;
      mdl_wait  <= 0;
      mdl_res   <= '0;
      mdl_rerr  <= 1'b0;
    end else if (mdl_ready) begin
      if (i_in_valid) begin
        mdl_ready <= 1'b0;
        mdl_wait  <= NCH;
        mdl_res   <= ref_res(i_sum, i_carry, i_q);
        mdl_rerr  <= ref_rerr(i_sum, i_carry, i_q);
      end
    end else if (mdl_wait > 0) begin
      mdl_wait <= mdl_wait - 1;
      if (mdl_wait == 1) mdl_valid <= 1'b1;
    end else if (mdl_valid && i_out_ready) begin
      mdl_valid <= 1'b0;
      mdl_ready <= 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("in_ready", {255'd0, o_in_ready}, {255'd0, mdl_ready});
      chk("out_valid", {255'd0, o_out_valid}, {255'd0, mdl_valid});
      if (mdl_valid) begin
        chk("result", {1'b0, o_result}, {1'b0, mdl_res});
`ifdef CS_RESOLVE_RANGE_CHK_EN
        chk("range_err", {255'd0, o_range_err}, {255'd0, mdl_rerr});
`endif
      end
    end
  end

  task automatic wait_valid(input string nm, output int n, output bit seen);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      @(posedge i_clk); #1;
      n++;
      if (o_out_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no o_out_valid after %0d cycles, want %0d", nm, n, NCH);
    end
  endtask

  // Called just after a rising edge with the block idle and i_out_ready high.
  task automatic run_pair(input logic [255:0] s, input logic [255:0] c, input logic [254:0] q,
                          input logic [255:0] exp, input string nm);
    int n;
    bit seen;
    i_sum = s; i_carry = c; i_q = q; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    wait_valid(nm, n, seen);
    if (seen) begin
      chk({nm, "_lat"}, 256'(n), 256'(NCH));
      chk({nm, "_res"}, {1'b0, o_result}, exp);
    end
    @(posedge i_clk); #1;
    chk({nm, "_idle"}, {255'd0, o_in_ready}, 256'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  n;
    bit  seen;
    logic [254:0] r0;
    logic [255:0] t;
    t    = (256'd1 << 255) - 256'd19;
    QM   = t[254:0];
    Q256 = {1'b0, QM};

    i_rst = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
    i_sum = '0; i_carry = '0; i_q = '0;
    #1 i_rst = 1'b1;
    #12;
    chk("rst_in_ready", {255'd0, o_in_ready}, 256'd1);
    chk("rst_out_valid", {255'd0, o_out_valid}, 256'd0);
    chk("rst_result", {1'b0, o_result}, 256'd0);
`ifdef CS_RESOLVE_RANGE_CHK_EN
    chk("rst_range_err", {255'd0, o_range_err}, 256'd0);
`endif
    @(negedge i_clk);
    i_rst  = 1'b0;
    cmp_en = 1'b1;
    @(posedge i_clk); #1;

    run_pair(Q256, 256'd0, QM, 256'd0, "v_eq_q");
    run_pair(Q256 - 256'd1, 256'd1, QM, 256'd0, "qm1_plus1");
    run_pair(Q256 - 256'd1, 256'd0, QM, Q256 - 256'd1, "v_eq_qm1");
    run_pair(256'd7, 256'd12, QM, 256'd19, "small");
    run_pair((256'd1 << 128) - 256'd1, 256'd1, QM, 256'd1 << 128, "carry_128");
    run_pair((256'd1 << 255) - 256'd1, 256'd1, QM, 256'd19, "carry_all");
    run_pair(Q256 - (256'd1 << 64), 256'd1 << 65, QM, 256'd1 << 64, "sub_q_mid");
    run_pair(256'd1500, 256'd400, 255'd1000, 256'd900, "q1000");
    // V = 2Q breaks the contract; result is V - Q truncated.
    run_pair(Q256, Q256, QM, Q256, "v_eq_2q");

    // Backpressure: result held while the consumer stalls; input pulses ignored.
    i_out_ready = 1'b0;
    i_sum = 256'd12345; i_carry = 256'd2; i_q = QM; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    wait_valid("stall", n, seen);
    if (seen) begin
      r0 = o_result;
      chk("stall_first", {1'b0, r0}, 256'd12347);
      for (int i = 0; i < 5; i++) begin
        i_in_valid = (i % 2 == 0);
        i_sum      = 256'd99 + 256'(i);
        @(posedge i_clk); #1;
        chk("stall_res", {1'b0, o_result}, 256'd12347);
        chk("stall_valid", {255'd0, o_out_valid}, 256'd1);
        chk("stall_in_ready", {255'd0, o_in_ready}, 256'd0);
      end
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("stall_release_valid", {255'd0, o_out_valid}, 256'd0);
    chk("stall_release_ready", {255'd0, o_in_ready}, 256'd1);

    // Asynchronous reset in the middle of chunk 4.
    i_sum = Q256 - 256'd1; i_carry = 256'd0; i_q = QM; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    repeat (4) @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    chk("arst_in_ready", {255'd0, o_in_ready}, 256'd1);
    chk("arst_out_valid", {255'd0, o_out_valid}, 256'd0);
    chk("arst_result", {1'b0, o_result}, 256'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk); #1;
      chk("arst_no_valid", {255'd0, o_out_valid}, 256'd0);
    end
    run_pair(Q256, 256'd5, QM, 256'd5, "after_rst");

`ifdef CS_RESOLVE_RANGE_CHK_EN
    // Range flag: V = 2Q is out of range, V = 2Q-2 is not.
    i_sum = Q256; i_carry = Q256; i_q = QM; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    wait_valid("rerr_hi", n, seen);
    if (seen) chk("rerr_hi_flag", {255'd0, o_range_err}, 256'd1);
    @(posedge i_clk); #1;
    i_sum = Q256; i_carry = Q256 - 256'd2; i_q = QM; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    wait_valid("rerr_lo", n, seen);
    if (seen) begin
      chk("rerr_lo_flag", {255'd0, o_range_err}, 256'd0);
      chk("rerr_lo_res", {1'b0, o_result}, Q256 - 256'd2);
    end
    @(posedge i_clk); #1;
`endif

    repeat (2) @(posedge i_clk);
    #1;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
